// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared types for the idli core decode path
//
// Provides the SQI beat nibble type, register/predicate types, the decoded
// operation record (op_t), the raw instruction layout (insn_t), the opcode
// enumeration and the decode stage state enumeration.

package idli_pkg;

    // One nibble from a single SQI memory.
    typedef logic [3:0] sqi_data_t;

    // General register index and predicate register index.
    typedef logic [2:0] reg_t;
    typedef logic [1:0] preg_t;

    // Predicate register that is always true; the default destination for q.
    localparam preg_t PREG_PT = 2'd3;

    typedef enum logic [1:0] {
        ALU_OP_ADD = 2'd0,
        ALU_OP_AND = 2'd1,
        ALU_OP_OR  = 2'd2,
        ALU_OP_XOR = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        B_SRC_REG  = 2'd0,
        B_SRC_ZERO = 2'd1,
        B_SRC_PC   = 2'd2
    } b_src_t;

    typedef enum logic {
        C_SRC_REG = 1'b0,
        C_SRC_IMM = 1'b1
    } c_src_t;

    // Encodings 9..15 are reserved and have no name.
    typedef enum logic [3:0] {
        OPC_ADD   = 4'd0,
        OPC_SUB   = 4'd1,
        OPC_AND   = 4'd2,
        OPC_OR    = 4'd3,
        OPC_XOR   = 4'd4,
        OPC_ANDN  = 4'd5,
        OPC_MOV   = 4'd6,
        OPC_ADDPC = 4'd7,
        OPC_CMP   = 4'd8
    } opcode_t;

    // Raw 16-bit instruction word, MSB first.
    typedef struct packed {
        preg_t   p;
        opcode_t opcode;
        reg_t    a;
        reg_t    b;
        reg_t    c;
        logic    imm;
    } insn_t;

    // Decoded operation handed to the execute stage.
    typedef struct packed {
        preg_t   p;
        preg_t   q;
        reg_t    a;
        reg_t    b;
        reg_t    c;
        logic    a_vld;
        logic    b_vld;
        logic    c_vld;
        b_src_t  b_src;
        c_src_t  c_src;
        alu_op_t alu_op;
        logic    alu_cin;
        logic    alu_rhs_inv;
    } op_t;

    typedef enum logic [2:0] {
        INSN_LO = 3'd0,
        INSN_HI = 3'd1,
        IMM_LO  = 3'd2,
        IMM_HI  = 3'd3,
        FULL    = 3'd4
    } decode_state_t;

endpackage

// File: rtl/idli_decode_fields.sv
// rtl/idli_decode_fields.sv - combinational instruction word to op_t decoder
//
// Ports:
//   i_insn    - assembled 16-bit instruction
//   o_op      - decoded operation
//   o_illegal - reserved opcode seen (only when IDLI_DECODE_ILLEGAL_EN is
//               defined; otherwise tied low and reserved opcodes act as ADD)

module idli_decode_fields
    import idli_pkg::*;
(
    input  insn_t i_insn,
    output op_t   o_op,
    output logic  o_illegal
);

    always_comb begin
        // Fields common to every opcode; the case below only overrides.
        o_op.p           = i_insn.p;
        o_op.q           = PREG_PT;
        o_op.a           = i_insn.a;
        o_op.b           = i_insn.b;
        o_op.c           = i_insn.c;
        o_op.a_vld       = 1'b1;
        o_op.b_vld       = 1'b1;
        o_op.c_vld       = ~i_insn.imm;
        o_op.c_src       = i_insn.imm ? C_SRC_IMM : C_SRC_REG;
        o_op.b_src       = B_SRC_REG;
        o_op.alu_op      = ALU_OP_ADD;
        o_op.alu_cin     = 1'b0;
        o_op.alu_rhs_inv = 1'b0;
        o_illegal        = 1'b0;

        case (i_insn.opcode)
            OPC_ADD: ;
            OPC_SUB: begin
                o_op.alu_cin     = 1'b1;
                o_op.alu_rhs_inv = 1'b1;
            end
            OPC_AND: o_op.alu_op = ALU_OP_AND;
            OPC_OR:  o_op.alu_op = ALU_OP_OR;
            OPC_XOR: o_op.alu_op = ALU_OP_XOR;
            OPC_ANDN: begin
                o_op.alu_op      = ALU_OP_AND;
                o_op.alu_rhs_inv = 1'b1;
            end
            OPC_MOV: begin
                o_op.b_src = B_SRC_ZERO;
                o_op.b_vld = 1'b0;
            end
            OPC_ADDPC: begin
                o_op.b_src = B_SRC_PC;
                o_op.b_vld = 1'b0;
            end
            OPC_CMP: begin
                // Compare writes a predicate selected by the low bits of A,
                // so A is not a register read.
                o_op.alu_cin     = 1'b1;
                o_op.alu_rhs_inv = 1'b1;
                o_op.q           = i_insn.a[1:0];
                o_op.a_vld       = 1'b0;
            end
`ifdef IDLI_DECODE_ILLEGAL_EN
            default: begin
                o_op      = '0;
                o_op.p    = i_insn.p;
                o_illegal = 1'b1;
            end
`else
            default: ;
`endif
        endcase
    end

endmodule

// File: rtl/idli_decode.sv
// rtl/idli_decode.sv - idli decode stage: beat assembly, FSM, output register
//
// Optional feature macro: IDLI_DECODE_ILLEGAL_EN (flag reserved opcodes).
//
// Ports:
//   i_clk, i_rst_n      - clock, asynchronous active-low reset
//   i_flush             - drop any partial or held instruction
//   i_sqi_lo, i_sqi_hi  - beat low/high nibble, i_vld/o_rdy handshake
//   o_op, o_imm         - registered decoded op and trailing immediate
//   o_illegal           - registered reserved-opcode flag
//   o_vld, i_rdy        - output handshake to execute

module idli_decode
    import idli_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_flush,
    input  sqi_data_t i_sqi_lo,
    input  sqi_data_t i_sqi_hi,
    input  logic      i_vld,
    output logic      o_rdy,
    output op_t       o_op,
    output logic [15:0] o_imm,
    output logic      o_illegal,
    output logic      o_vld,
    input  logic      i_rdy
);

    decode_state_t state;
    logic [7:0]    lo_q;      // first byte of the instruction or immediate
    logic [7:0]    beat;
    logic          beat_acc;
    logic          out_hs;
    insn_t         cur_insn;
    op_t           dec_op;
    logic          dec_illegal;

    assign beat     = {i_sqi_hi, i_sqi_lo};
    assign o_vld    = (state == FULL);
    assign o_rdy    = (state != FULL) | i_rdy;
    assign beat_acc = i_vld & o_rdy;
    assign out_hs   = o_vld & i_rdy;

    // Only meaningful in INSN_HI, where the incoming beat is the high byte.
    assign cur_insn = insn_t'({beat, lo_q});

    idli_decode_fields u_fields (
        .i_insn    (cur_insn),
        .o_op      (dec_op),
        .o_illegal (dec_illegal)
    );

    // The op is registered as soon as the instruction word is complete,
    // even when an immediate follows: o_vld is low until the immediate
    // arrives, so the early load is not visible to the consumer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= INSN_LO;
            lo_q      <= 8'h00;
            o_op      <= '0;
            o_imm     <= 16'h0000;
            o_illegal <= 1'b0;
        end else if (i_flush) begin
            state <= INSN_LO;
        end else begin
            case (state)
                INSN_LO: begin
                    if (beat_acc) begin
                        lo_q  <= beat;
                        state <= INSN_HI;
                    end
                end
                INSN_HI: begin
                    if (beat_acc) begin
                        o_op      <= dec_op;
                        o_illegal <= dec_illegal;
                        state     <= cur_insn.imm ? IMM_LO : FULL;
                    end
                end
                IMM_LO: begin
                    if (beat_acc) begin
                        lo_q  <= beat;
                        state <= IMM_HI;
                    end
                end
                IMM_HI: begin
                    if (beat_acc) begin
                        o_imm <= {beat, lo_q};
                        state <= FULL;
                    end
                end
                FULL: begin
                    // A beat is only accepted here alongside the handshake,
                    // and it is the first byte of the next instruction.
                    if (out_hs) begin
                        if (beat_acc) begin
                            lo_q  <= beat;
                            state <= INSN_HI;
                        end else begin
                            state <= INSN_LO;
                        end
                    end
                end
                default: state <= INSN_LO;
            endcase
        end
    end

endmodule

// File: doc/idli_decode.md
# idli_decode

Instruction decode stage for the idli core. Assembles 16-bit instructions, and an optional trailing 16-bit immediate, from byte-wide beats formed by the two SQI memories (low nibble from `SQI_MEM_LO`, high nibble from `SQI_MEM_HI`). It decodes each instruction into an `op_t` and holds it in an output register with a valid/ready handshake for the execute stage.

## Interface
Parameters: none.

- `i_clk  in  1` — core clock. There is one clock.
- `i_rst_n  in  1` — reset, asynchronous, active-low.
- `i_flush  in  1` — drops any partial or held instruction.
- `i_sqi_lo  in  4` — beat low nibble (`sqi_data_t`).
- `i_sqi_hi  in  4` — beat high nibble (`sqi_data_t`).
- `i_vld  in  1` — beat valid.
- `o_rdy  out  1` — beat accepted when `i_vld & o_rdy`.
- `o_op  out  $bits(op_t)` — decoded operation.
- `o_imm  out  16` — immediate; meaningful only when `o_op.c_src == C_SRC_IMM`.
- `o_illegal  out  1` — reserved opcode flag.
- `o_vld  out  1` — decoded op held.
- `i_rdy  in  1` — consumer accepts when `o_vld & i_rdy`.

## Operation
- Byte order: the first beat is bits [7:0] and the second beat is bits [15:8]. Immediates use the same order.
- Instruction fields:
  - [15:14] P
  - [13:10] opcode
  - [9:7] A
  - [6:4] B
  - [3:1] C
  - [0] I (immediate follows)
- Defaults for every opcode:
  - `p`=P, `a`/`b`/`c` from their fields.
  - `q`=`PREG_PT`.
  - `a_vld`=`b_vld`=1, `c_vld`=!I.
  - `c_src`=I ? `C_SRC_IMM` : `C_SRC_REG`.
  - `b_src`=`B_SRC_REG`, `alu_cin`=0, `alu_rhs_inv`=0.
- Opcodes (differences from the defaults):
  - 0 ADD: `ALU_OP_ADD`.
  - 1 SUB: ADD, with cin=1 and inv=1.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 ANDN: AND with inv=1.
  - 6 MOV: ADD, `b_src`=`B_SRC_ZERO`, `b_vld`=0.
  - 7 ADDPC: ADD, `b_src`=`B_SRC_PC`, `b_vld`=0.
  - 8 CMP: SUB, `q`=A[1:0], `a_vld`=0.
  - 9–15: reserved.
- State machine, with transitions on an accepted beat unless noted:
  - INSN_LO → INSN_HI.
  - INSN_HI → IMM_LO if I=1, else FULL.
  - IMM_LO → IMM_HI.
  - IMM_HI → FULL.
  - FULL → INSN_LO when the output handshake completes with no beat accepted.
  - FULL → INSN_HI when the handshake completes and a beat is accepted in the same cycle.
- `o_rdy` = (state != FULL) | i_rdy. Beats in FULL are accepted only in a handshake cycle.
- `o_vld` = (state == FULL).
- `o_op`, `o_imm` and `o_illegal` are registered. They are stable while `o_vld & !i_rdy`.
- `o_imm` is loaded only for I=1 instructions and otherwise holds its value.
- Flush takes priority over every other event: next state is INSN_LO, and any beat or handshake in that cycle is ignored.

## Timing
- Reset values:
  - state INSN_LO.
  - `o_vld`=0, `o_rdy`=1 (combinational).
  - `o_op`=0, `o_imm`=0, `o_illegal`=0.
- Latency: `o_vld` rises in the cycle after the last beat is accepted.
- Throughput:
  - Back-to-back with `i_rdy` held high: one instruction per 2 beats, or per 4 beats with an immediate.
  - Zero bubble cycles between instructions.
- `i_vld` low mid-instruction stalls the block in its current state. Data may be split across arbitrary gaps.
- Reset asserted mid-instruction discards the partial instruction immediately; it is asynchronous.

## Configuration
- Macro: `IDLI_DECODE_ILLEGAL_EN`.
- Defined:
  - Reserved opcodes set `o_illegal`=1.
  - `o_op` is zeroed except `p`.
  - The op is still presented and handshaked.
- Undefined:
  - `o_illegal` is tied to 0.
  - Reserved opcodes decode exactly as ADD.

## Structure
- `idli_pkg` gains:
  - `opcode_t` (4-bit enum of the opcodes above).
  - `insn_t` (packed struct of the instruction fields).
  - `decode_state_t` (INSN_LO, INSN_HI, IMM_LO, IMM_HI, FULL).
- Sub-module `idli_decode_fields`: purely combinational `insn_t` → `op_t` + illegal.
- The top module holds the FSM, the byte assembly register and the output registers.

## Test plan
- Beats 0xA6, 0xC0 (0xC0A6) with `i_rdy`=1 → next cycle `o_vld`=1:
  - p=3, q=3, a=1, b=2, c=3.
  - all vld=1, C_SRC_REG.
  - ADD, cin=0, inv=0.
- Beats 0x21, 0x05, 0x34, 0x12 → `o_vld` only after the fourth beat:
  - SUB: cin=1, inv=1.
  - C_SRC_IMM, `c_vld`=0.
  - `o_imm`=0x1234.
- 0xE0CA (CMP) → q=1, `a_vld`=0, b=4, c=5, cin=1, inv=1.
- 0xFC00:
  - With the macro → `o_illegal`=1.
  - Without the macro → ADD, `o_illegal`=0.
- Backpressure:
  - `i_rdy`=0 for 5 cycles after FULL → `o_op` stable and `o_rdy`=0.
  - Release together with the next first beat → zero-bubble acceptance.
- Flush and reset:
  - `i_flush` after one beat → state INSN_LO; the next two beats decode a fresh instruction.
  - `i_rst_n` low in FULL → `o_vld`=0 asynchronously.
